// File: rtl/alu_reg_sequencer_if.sv
// rtl/alu_reg_sequencer_if.sv - command channel between a host and the ALU register sequencer
interface alu_reg_sequencer_if #(
  parameter int REG_AW = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    output cmd_ready
  );
endinterface

// File: rtl/alu_reg_sequencer.sv
// rtl/alu_reg_sequencer.sv - operand register file and command sequencer feeding a combinational ALU
module alu_reg_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REG_AW        = 3
) (
  input  logic                clk,
  input  logic                reset,
  alu_reg_sequencer_if.slave  cmd,
  input  logic                wr_en,
  input  logic [REG_AW-1:0]   wr_addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [3:0]          alu_op,
  input  logic [31:0]         alu_result,
  input  logic                alu_zero,
  output logic                done,
  output logic                zero_flag,
  output logic [31:0]         last_result,
  input  logic [REG_AW-1:0]   dbg_addr,
  output logic [31:0]         dbg_data
);
  localparam int DEPTH = 1 << REG_AW;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state_q, state_d;
  logic              accept, writeback;
  logic [3:0]        cnt_q;
  logic [REG_AW-1:0] rd_q;
  logic [31:0]       regs_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    writeback = 1'b0;
    case (state_q)
      IDLE: if (cmd.cmd_valid) begin
        accept  = 1'b1;
        state_d = EXEC;
      end
      EXEC: if (cnt_q == 4'd0) begin
        writeback = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state_q == IDLE);

  // Writeback is issued after the host write so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr_en)     regs_q[wr_addr] <= wr_data;
      if (writeback) regs_q[rd_q]    <= alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      done        <= 1'b0;
      zero_flag   <= 1'b0;
      last_result <= '0;
    end else begin
      done <= writeback;
      if (accept) begin
        alu_a  <= regs_q[cmd.cmd_rs1];
        alu_b  <= regs_q[cmd.cmd_rs2];
        alu_op <= cmd.cmd_op;
        rd_q   <= cmd.cmd_rd;
        cnt_q  <= 4'(SETTLE_CYCLES - 1);
      end else if (state_q == EXEC && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (writeback) begin
        last_result <= alu_result;
        zero_flag   <= alu_zero;
      end
    end
  end

  assign dbg_data = regs_q[dbg_addr];
endmodule
